// File: rtl/core_wb.sv
// core_wb: writeback stage feeding the integer register file.
// Accepts one op per START (ALU write, memory load, 8-bit input), runs the
// load-memory / input-port handshake and drives the register-file write ports.
// The register file samples WE/INE one cycle late, so WADDR/WDATA/INDATA are
// held through the HOLD cycle that follows WRITE.
// Optional feature: define CORE_WB_BYPASS_EN to add FWD_VALID/FWD_ADDR/FWD_DATA.
// All outputs are registered from the next-state decode, so each output is
// aligned with the state it belongs to.

module core_wb #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [2:0]  FUNCT3,
  input  logic [4:0]  RD,
  input  logic [31:0] ALU_RESULT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        MEM_RE,
  output logic [31:0] MEM_ADDR,
  input  logic        MEM_RVALID,
  input  logic [31:0] MEM_RDATA,
  input  logic        IN_VALID,
  input  logic [7:0]  IN_DATA,
  output logic        IN_READY,
  output logic [4:0]  WADDR,
  output logic        WE,
  output logic [31:0] WDATA,
  output logic        INE,
  output logic [7:0]  INDATA
`ifdef CORE_WB_BYPASS_EN
  ,
  output logic        FWD_VALID,
  output logic [4:0]  FWD_ADDR,
  output logic [31:0] FWD_DATA
`endif
);

  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [1:0] OP_ALU  = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_IN   = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_IN_WAIT,
    S_WRITE,
    S_HOLD
  } state_t;

  state_t           state, state_n;
  logic [1:0]       op_q, op_n;
  logic [2:0]       f3_q, f3_n;
  logic [4:0]       rd_q, rd_n;
  logic [1:0]       alo_q, alo_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;

  logic        busy_n, done_n, err_n, mem_re_n, in_ready_n, we_n, ine_n;
  logic [31:0] mem_addr_n, wdata_n;
  logic [4:0]  waddr_n;
  logic [7:0]  indata_n;

  logic        load_bad;
  logic        timeout_hit;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;

  // Reject unsupported load widths and misaligned half/word addresses at launch
  always_comb begin
    load_bad = 1'b0;
    case (FUNCT3)
      F3_LB, F3_LBU: load_bad = 1'b0;
      F3_LH, F3_LHU: load_bad = ALU_RESULT[0];
      F3_LW:         load_bad = (ALU_RESULT[1:0] != 2'b00);
      default:       load_bad = 1'b1;
    endcase
  end

  // Pick the addressed byte/half of the little-endian word and extend it
  always_comb begin
    rd_byte  = MEM_RDATA[7:0];
    case (alo_q)
      2'd0:    rd_byte = MEM_RDATA[7:0];
      2'd1:    rd_byte = MEM_RDATA[15:8];
      2'd2:    rd_byte = MEM_RDATA[23:16];
      default: rd_byte = MEM_RDATA[31:24];
    endcase
    rd_half  = alo_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    load_ext = MEM_RDATA;
    case (f3_q)
      F3_LB:   load_ext = {{24{rd_byte[7]}}, rd_byte};
      F3_LH:   load_ext = {{16{rd_half[15]}}, rd_half};
      F3_LBU:  load_ext = {24'd0, rd_byte};
      F3_LHU:  load_ext = {16'd0, rd_half};
      default: load_ext = MEM_RDATA;
    endcase
  end

  // Wait abort fires on the TIMEOUT-th waiting cycle; disabled when TIMEOUT is 0
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));
  end

  // Next-state and next-output decode
  always_comb begin
    state_n    = state;
    op_n       = op_q;
    f3_n       = f3_q;
    rd_n       = rd_q;
    alo_n      = alo_q;
    cnt_n      = cnt_q;
    mem_addr_n = MEM_ADDR;
    waddr_n    = WADDR;
    wdata_n    = WDATA;
    indata_n   = INDATA;
    busy_n     = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    mem_re_n   = 1'b0;
    in_ready_n = 1'b0;
    we_n       = 1'b0;
    ine_n      = 1'b0;

    case (state)
      S_IDLE: begin
        if (START) begin
          op_n  = OP;
          f3_n  = FUNCT3;
          rd_n  = RD;
          alo_n = ALU_RESULT[1:0];
          case (OP)
            OP_ALU: begin
              state_n = S_WRITE;
              wdata_n = ALU_RESULT;
            end
            OP_LOAD: begin
              if (load_bad) begin
                state_n = S_HOLD;
                err_n   = 1'b1;
              end else begin
                state_n    = S_MEM_REQ;
                mem_addr_n = {ALU_RESULT[31:2], 2'b00};
              end
            end
            OP_IN: begin
              state_n = S_IN_WAIT;
              cnt_n   = '0;
            end
            default: state_n = S_HOLD;
          endcase
        end
      end
      S_MEM_REQ: begin
        state_n = S_MEM_WAIT;
        cnt_n   = '0;
      end
      S_MEM_WAIT: begin
        if (MEM_RVALID) begin
          state_n = S_WRITE;
          wdata_n = load_ext;
        end else if (timeout_hit) begin
          state_n = S_HOLD;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_IN_WAIT: begin
        if (IN_VALID) begin
          state_n  = S_WRITE;
          indata_n = IN_DATA;
        end else if (timeout_hit) begin
          state_n = S_HOLD;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: state_n = S_HOLD;
      S_HOLD:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (state_n == S_WRITE) begin
      waddr_n = rd_n;
      we_n    = (op_n != OP_IN) && (rd_n != 5'd0);
      ine_n   = (op_n == OP_IN) && (rd_n != 5'd0);
    end
    busy_n     = (state_n != S_IDLE);
    done_n     = (state_n == S_HOLD);
    mem_re_n   = (state_n == S_MEM_REQ);
    in_ready_n = (state_n == S_IN_WAIT);
  end

  // State, latched op fields and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= S_IDLE;
      op_q     <= 2'd0;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      alo_q    <= 2'd0;
      cnt_q    <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      MEM_RE   <= 1'b0;
      MEM_ADDR <= 32'd0;
      IN_READY <= 1'b0;
      WADDR    <= 5'd0;
      WE       <= 1'b0;
      WDATA    <= 32'd0;
      INE      <= 1'b0;
      INDATA   <= 8'd0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      f3_q     <= f3_n;
      rd_q     <= rd_n;
      alo_q    <= alo_n;
      cnt_q    <= cnt_n;
      BUSY     <= busy_n;
      DONE     <= done_n;
      ERR      <= err_n;
      MEM_RE   <= mem_re_n;
      MEM_ADDR <= mem_addr_n;
      IN_READY <= in_ready_n;
      WADDR    <= waddr_n;
      WE       <= we_n;
      WDATA    <= wdata_n;
      INE      <= ine_n;
      INDATA   <= indata_n;
    end
  end

`ifdef CORE_WB_BYPASS_EN
  // Forward valid covers the WRITE cycle and the following HOLD cycle of a WE write
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      FWD_VALID <= 1'b0;
    end else begin
      FWD_VALID <= we_n | WE;
    end
  end

  assign FWD_ADDR = WADDR;
  assign FWD_DATA = WDATA;
`endif

endmodule
